// File: rtl/data_mem_dma.sv
// rtl/data_mem_dma.sv - byte copy/fill DMA initiator on the 8-bit data-memory port
// Fill mode is built only when DMA_FILL_EN is defined; otherwise every transfer is a copy.
module data_mem_dma (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       mode,
   input  logic [7:0] src_addr,
   input  logic [7:0] dst_addr,
   input  logic [7:0] length,
   input  logic [7:0] fill_data,
   input  logic       abort,
   output logic       busy,
   output logic       done,
   output logic [7:0] bytes_done,
   output logic       mem_read,
   output logic       mem_write,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} stateT;

   stateT      state;
   logic [7:0] srcBase;
   logic [7:0] dstBase;
   logic [7:0] xferLen;
   logic [7:0] index;
   logic [7:0] nextIndex;
   logic       fillReq;
   logic [7:0] fillIn;
   logic       fillMode;
   logic [7:0] fillByte;

   assign nextIndex = index + 8'd1;

`ifdef DMA_FILL_EN
   assign fillReq = mode;
   assign fillIn  = fill_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fillMode <= 1'b0;
         fillByte <= 8'h00;
      end else if (state == IDLE && start) begin
         fillMode <= mode;
         fillByte <= fill_data;
      end
   end
`else
   logic unusedFillInputs;
   assign unusedFillInputs = ^{mode, fill_data};
   assign fillReq  = 1'b0;
   assign fillIn   = 8'h00;
   assign fillMode = 1'b0;
   assign fillByte = 8'h00;
`endif

   // Outputs are registered alongside the next state, so the memory port
   // never sees a combinational path from start/abort. In copy mode the
   // registered write-data doubles as the byte buffer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         bytes_done <= 8'h00;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= 8'h00;
         mem_wdata  <= 8'h00;
         srcBase    <= 8'h00;
         dstBase    <= 8'h00;
         xferLen    <= 8'h00;
         index      <= 8'h00;
      end else begin
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= 8'h00;
         mem_wdata <= 8'h00;
         case (state)
            IDLE: begin
               if (start) begin
                  srcBase    <= src_addr;
                  dstBase    <= dst_addr;
                  xferLen    <= length;
                  index      <= 8'h00;
                  bytes_done <= 8'h00;
                  if (length == 8'h00) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else if (fillReq) begin
                     state     <= WRITE;
                     busy      <= 1'b1;
                     mem_write <= 1'b1;
                     mem_addr  <= dst_addr;
                     mem_wdata <= fillIn;
                  end else begin
                     state    <= READ;
                     busy     <= 1'b1;
                     mem_read <= 1'b1;
                     mem_addr <= src_addr;
                  end
               end
            end
            READ: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  state     <= WRITE;
                  busy      <= 1'b1;
                  mem_write <= 1'b1;
                  mem_addr  <= dstBase + index;
                  mem_wdata <= mem_rdata;
               end
            end
            WRITE: begin
               // The write driven this cycle commits at this edge, even on abort.
               index      <= nextIndex;
               bytes_done <= bytes_done + 8'd1;
               if (abort) begin
                  state <= IDLE;
               end else if (nextIndex == xferLen) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else if (fillMode) begin
                  state     <= WRITE;
                  busy      <= 1'b1;
                  mem_write <= 1'b1;
                  mem_addr  <= dstBase + nextIndex;
                  mem_wdata <= fillByte;
               end else begin
                  state    <= READ;
                  busy     <= 1'b1;
                  mem_read <= 1'b1;
                  mem_addr <= srcBase + nextIndex;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_dma.sv
// tb/tb_data_mem_dma.sv - vector table plus write scoreboard for data_mem_dma
// Honours DMA_FILL_EN to select fill or copy expectations for mode=1 rows.
module tb_data_mem_dma;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       mode;
   logic [7:0] src_addr;
   logic [7:0] dst_addr;
   logic [7:0] length;
   logic [7:0] fill_data;
   logic       abort;
   logic       busy;
   logic       done;
   logic [7:0] bytes_done;
   logic       mem_read;
   logic       mem_write;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

`ifdef DMA_FILL_EN
   localparam bit FillEn = 1'b1;
`else
   localparam bit FillEn = 1'b0;
`endif

   data_mem_dma dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
      .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
      .bytes_done(bytes_done), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [256];
   logic [7:0] model [256];
   logic       preload;

   assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= model[i];
      end else if (mem_write) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   typedef struct {
      logic       mode;
      logic [7:0] src;
      logic [7:0] dst;
      logic [7:0] len;
      logic [7:0] fill;
      int         abortCyc;
      int         rstCyc;
      int         strayCyc;
      logic       abortAtStart;
      int         expDone;
      int         busyEnd;
      int         expWrites;
      int         expBytes;
   } vecT;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wrT;

   vecT vecs[$];
   wrT  sb[$];
   int  errors = 0;
   int  checks = 0;

   function automatic vecT mk(input logic m, input logic [7:0] s, input logic [7:0] d,
                              input logic [7:0] l, input logic [7:0] f, input int ab,
                              input int rs, input int st, input logic abs, input int ed,
                              input int be, input int ew, input int eb);
      vecT v;
      v.mode = m; v.src = s; v.dst = d; v.len = l; v.fill = f;
      v.abortCyc = ab; v.rstCyc = rs; v.strayCyc = st; v.abortAtStart = abs;
      v.expDone = ed; v.busyEnd = be; v.expWrites = ew; v.expBytes = eb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic runVec(input vecT v, input int idx);
      logic       isFill;
      logic       inBusy;
      logic       expRead;
      logic       expWrite;
      logic [7:0] a;
      logic [7:0] s;
      logic [7:0] d;
      int         maxCyc;
      int         bad;
      wrT         w;
      isFill = v.mode && FillEn;
      for (int i = 0; i < v.expWrites; i++) begin
         a = v.dst + 8'(i);
         s = v.src + 8'(i);
         d = isFill ? v.fill : model[s];
         model[a] = d;
         sb.push_back({a, d});
      end
      maxCyc = (v.rstCyc > 0) ? v.rstCyc + 3 : v.busyEnd + 2;
      @(negedge clk);
      mode = v.mode; src_addr = v.src; dst_addr = v.dst; length = v.len;
      fill_data = v.fill; start = 1'b1; abort = v.abortAtStart;
      @(posedge clk);
      #1;
      start = 1'b0; abort = 1'b0;
      for (int c = 1; c <= maxCyc; c++) begin
         @(negedge clk);
         start = 1'b0; abort = 1'b0;
         inBusy   = (c <= v.busyEnd);
         expRead  = inBusy && !isFill && (c % 2 == 1);
         expWrite = inBusy && (isFill || (c % 2 == 0));
         chk($sformatf("v%0d c%0d busy", idx, c), busy, inBusy);
         chk($sformatf("v%0d c%0d done", idx, c), done, c == v.expDone);
         chk($sformatf("v%0d c%0d mem_read", idx, c), mem_read, expRead);
         chk($sformatf("v%0d c%0d mem_write", idx, c), mem_write, expWrite);
         if (mem_read && expRead) begin
            s = v.src + 8'((c - 1) / 2);
            chk($sformatf("v%0d c%0d read addr", idx, c), mem_addr, s);
         end
         if (mem_write) begin
            if (sb.size() == 0) begin
               chk($sformatf("v%0d c%0d unexpected write", idx, c), 1, 0);
            end else begin
               w = sb.pop_front();
               chk($sformatf("v%0d c%0d write addr", idx, c), mem_addr, w.addr);
               chk($sformatf("v%0d c%0d write data", idx, c), mem_wdata, w.data);
            end
         end
         if (c == v.strayCyc) start = 1'b1;
         if (c == v.abortCyc) abort = 1'b1;
         if (c == v.rstCyc) begin
            reset = 1'b1;
            #1;
            chk($sformatf("v%0d async reset outputs", idx),
                {busy, done, mem_read, mem_write, mem_addr, mem_wdata, bytes_done}, 0);
         end
         if (v.rstCyc > 0 && c == v.rstCyc + 2) reset = 1'b0;
      end
      start = 1'b0; abort = 1'b0;
      chk($sformatf("v%0d writes pending", idx), sb.size(), 0);
      sb.delete();
      chk($sformatf("v%0d bytes_done", idx), bytes_done, v.expBytes);
      chk($sformatf("v%0d idle mem_addr/wdata", idx), {mem_addr, mem_wdata}, 0);
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== model[i]) bad++;
      chk($sformatf("v%0d memory image bad bytes", idx), bad, 0);
   endtask

   initial begin
      reset = 1'b1; preload = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
      src_addr = 8'h00; dst_addr = 8'h00; length = 8'h00; fill_data = 8'h00;
      for (int i = 0; i < 256; i++) model[i] = 8'(i * 7 + 3);
      model[8'h10] = 8'hA1; model[8'h11] = 8'hB2; model[8'h12] = 8'hC3; model[8'h13] = 8'hD4;
      model[8'hFE] = 8'h11; model[8'hFF] = 8'h22; model[8'h00] = 8'h33;

      //            mode src    dst    len   fill  abt rst str abS done bEnd wr  bytes
      vecs.push_back(mk(0, 8'h10, 8'h40, 8'd4, 8'h00, 0, 0, 0, 1, 9, 8, 4, 4));
      vecs.push_back(mk(0, 8'hFE, 8'hFF, 8'd3, 8'h00, 0, 0, 0, 0, 7, 6, 3, 3));
      vecs.push_back(mk(0, 8'h55, 8'h66, 8'd0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 8'h20, 8'h60, 8'd8, 8'h00, 8, 0, 3, 0, 0, 8, 4, 4));
      vecs.push_back(mk(0, 8'h30, 8'h70, 8'd6, 8'h00, 0, 5, 0, 0, 0, 5, 2, 0));
      vecs.push_back(mk(0, 8'h30, 8'h70, 8'd6, 8'h00, 0, 0, 0, 0, 13, 12, 6, 6));
`ifdef DMA_FILL_EN
      vecs.push_back(mk(1, 8'h00, 8'h80, 8'd5, 8'h5A, 0, 0, 0, 0, 6, 5, 5, 5));
      vecs.push_back(mk(1, 8'h00, 8'hA0, 8'd10, 8'hC3, 3, 0, 0, 0, 0, 3, 3, 3));
`else
      vecs.push_back(mk(1, 8'h10, 8'h90, 8'd2, 8'h77, 0, 0, 0, 0, 5, 4, 2, 2));
`endif
      vecs.push_back(mk(0, 8'h00, 8'h01, 8'd255, 8'h00, 0, 0, 0, 0, 511, 510, 255, 255));

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset state outputs",
          {busy, done, mem_read, mem_write, mem_addr, mem_wdata, bytes_done}, 0);
      preload = 1'b0;
      reset = 1'b0;

      foreach (vecs[i]) runVec(vecs[i], i);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/data_mem_dma.md
# data_mem_dma

Block-copy/fill engine that acts as the initiator on the data-memory port of the 8-bit microprocessor. It drives the memory read-enable, write-enable, 8-bit address and write data, and captures the memory's combinational read data. The CPU starts it with a source, destination and length. It then moves bytes autonomously and signals completion with a one-cycle `done` pulse.

## Interface
- No parameters. Data width is 8 bits and the address space is 256 bytes, both fixed.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `mode` input 1: 0 = copy, 1 = fill. Sampled with `start`.
- `src_addr` input 8: copy source base address; ignored in fill mode.
- `dst_addr` input 8: destination base address.
- `length` input 8: byte count. 0 means no transfer.
- `fill_data` input 8: byte written in fill mode.
- `abort` input 1: cancels an active transfer.
- `busy` output 1: high in READ and WRITE states.
- `done` output 1: one-cycle pulse on normal completion.
- `bytes_done` output 8: bytes written so far in the current or last transfer.
- `mem_read` output 1: memory read enable.
- `mem_write` output 1: memory write enable.
- `mem_addr` output 8: memory address.
- `mem_wdata` output 8: memory write data.
- `mem_rdata` input 8: memory read data. The memory drives it combinationally from `mem_addr` while `mem_read` is high, and drives 0 otherwise.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE, on `start`=1:
  - Latch `src_addr`, `dst_addr`, `length`, `mode`, `fill_data`.
  - Clear `bytes_done`.
  - Next state: `length`=0 → DONE; copy mode → READ; fill mode → WRITE.
- READ:
  - Drive `mem_read`=1 and `mem_addr`=src+index.
  - Capture `mem_rdata` into the byte buffer at the edge.
  - Next state: WRITE.
- WRITE:
  - Drive `mem_write`=1, `mem_addr`=dst+index, `mem_wdata`= buffer (copy) or latched fill byte (fill).
  - The memory commits the byte at the edge.
  - At that edge, increment index and `bytes_done`.
  - Next state: if index+1 = length → DONE; otherwise READ (copy) or WRITE (fill).
- DONE:
  - `done`=1 for exactly one cycle.
  - Next state: IDLE.
- Address arithmetic is 8-bit modulo 256: src+index and dst+index wrap from 0xFF to 0x00.
- Copy is strictly ascending, byte-at-a-time. Overlapping regions with dst>src are copied literally; corruption is expected and not guarded against.
- `mem_read` and `mem_write` are never high in the same cycle.
- In IDLE and DONE, all `mem_*` outputs are 0.
- `start` while not in IDLE is ignored.
- `abort`, when sampled high in READ or WRITE:
  - Next state is IDLE; `done` does not pulse.
  - A write driven in that same cycle still commits, because the memory samples it at that edge.
  - `bytes_done` counts that committed write.
- `abort` in IDLE or DONE has no effect.
- `start` and `abort` both high in IDLE: `start` wins.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `bytes_done`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0; internal index and buffer 0.
- Reset asserted mid-transfer returns to IDLE immediately. No further memory accesses occur.
- All outputs are decoded from registered state only. There is no combinational path from `start` or `abort` to the `mem_*` outputs.
- Copy of N bytes (N≥1), with `start` sampled at edge E0:
  - Cycles 1..2N alternate READ/WRITE.
  - `done` is high in cycle 2N+1.
  - `busy` is high in cycles 1..2N.
- Fill of N bytes: WRITE in cycles 1..N; `done` in cycle N+1.
- `length`=0: `done` in cycle 1; no memory access; `busy` stays 0.
- Maximum transfer is 255 bytes.
- A new `start` is accepted in the cycle after DONE.

## Configuration
- `DMA_FILL_EN` defined:
  - Fill mode is implemented as described.
- `DMA_FILL_EN` undefined:
  - The `mode` and `fill_data` ports remain but are ignored; every transfer is a copy.
  - Fill datapath and mux are removed.

## Test plan
- Copy: preload mem[0x10..0x13] = 0xA1,0xB2,0xC3,0xD4; start src=0x10, dst=0x40, len=4 → mem[0x40..0x43] = same values; `done` in cycle 9; `busy` high in cycles 1–8; `bytes_done`=4.
- Wrap: src=0xFE, dst=0xFF, len=3, with mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33 → mem[0xFF]=0x11, mem[0x00]=0x11 (overlap propagation), mem[0x01]=0x11; addresses wrap through 0x00.
- Fill (`DMA_FILL_EN`): dst=0x80, len=5, fill_data=0x5A → mem[0x80..0x84]=0x5A; mem[0x85] unchanged; `done` in cycle 6; `mem_read` never high.
- Zero length: start len=0 → `done` in cycle 1; `mem_read`/`mem_write` stay 0; memory unchanged.
- Abort: copy len=8; assert `abort` in the 4th WRITE cycle (cycle 8) → 4 bytes copied; `bytes_done`=4; no `done` pulse; IDLE in cycle 9; `start` pulsed during the transfer ignored.
- Reset mid-transfer: assert `reset` during READ → all outputs 0 immediately; no further writes; subsequent transfer runs correctly.
